// File: rtl/mode_seq_pkg.sv
// Shared command encoding and index-stepping helper for the mode sequencer.
package mode_seq_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD   = 3'd0,
        CMD_NEXT   = 3'd1,
        CMD_PREV   = 3'd2,
        CMD_HOME   = 3'd3,
        CMD_JUMP   = 3'd4,
        CMD_LOCK   = 3'd5,
        CMD_UNLOCK = 3'd6,
        CMD_RSVD   = 3'd7
    } cmd_e;

    // dir=0 steps forward, dir=1 steps back; ends wrap or saturate per 'wrap'.
    function automatic logic [3:0] next_idx(input logic [3:0] s, input logic dir,
                                            input logic [4:0] n, input logic wrap);
        logic [4:0] last;
        last = n - 5'd1;
        next_idx = s;
        if (!dir) begin
            if ({1'b0, s} >= last) next_idx = wrap ? 4'd0 : s;
            else                   next_idx = s + 4'd1;
        end else begin
            if (s == 4'd0) next_idx = wrap ? last[3:0] : 4'd0;
            else           next_idx = s - 4'd1;
        end
    endfunction

endpackage

// File: rtl/mode_seq_fsm.sv
// Moore mode sequencer: steps through NUM_STATES modes on valid commands, with
// lock, minimum dwell and recovery from an out-of-range state register.
module mode_seq_fsm
    import mode_seq_pkg::*;
#(
    parameter int NUM_STATES = 4,
    parameter int OUT_W      = 3,
    parameter int WRAP       = 1,
    parameter int MIN_DWELL  = 0,
    localparam int STATE_W   = $clog2(NUM_STATES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [2:0]         user_input,
    input  logic [STATE_W-1:0] target,
    output logic [OUT_W-1:0]   out,
    output logic [STATE_W-1:0] state,
    output logic               locked,
    output logic               cmd_rej,
    output logic               fault
);

    localparam logic [STATE_W-1:0] MODE_HOME = '0;
    localparam logic [STATE_W:0]   N_EXT     = (STATE_W+1)'(NUM_STATES);
    localparam logic [4:0]         N5        = 5'(NUM_STATES);
    localparam logic [7:0]         MIN_D8    = 8'(MIN_DWELL);
    localparam logic               WRAP_B    = (WRAP != 0);

    logic [STATE_W-1:0] state_r, state_nxt;
    logic               locked_r, locked_nxt;
    logic               fault_r, fault_nxt;
    logic               rej_r, rej_nxt;
    logic [7:0]         dwell_r;
    logic               legal, tgt_ok, dwell_ok;
    logic [3:0]         fwd_idx, bwd_idx;
    cmd_e               cmd;

    assign cmd     = cmd_e'(user_input);
    assign fwd_idx = next_idx(4'(state_r), 1'b0, N5, WRAP_B);
    assign bwd_idx = next_idx(4'(state_r), 1'b1, N5, WRAP_B);

    // Power-of-two mode counts cannot encode an illegal state or target.
    generate
        if ((1 << STATE_W) == NUM_STATES) begin : g_full
            assign legal  = 1'b1;
            assign tgt_ok = 1'b1;
        end else begin : g_partial
            assign legal  = ({1'b0, state_r} < N_EXT);
            assign tgt_ok = ({1'b0, target} < N_EXT);
        end
        if (MIN_DWELL == 0) begin : g_no_dwell
            assign dwell_ok = 1'b1;
        end else begin : g_dwell
            assign dwell_ok = (dwell_r >= MIN_D8);
        end
    endgenerate

    always_comb begin
        state_nxt  = state_r;
        locked_nxt = locked_r;
        fault_nxt  = fault_r;
        rej_nxt    = 1'b0;
        case (legal)
            1'b1: begin
                if (in_valid) begin
                    if (cmd == CMD_UNLOCK) begin
                        locked_nxt = 1'b0;
                    end else if (cmd != CMD_HOLD) begin
                        if (locked_r) begin
                            rej_nxt = 1'b1;
                        end else begin
                            case (cmd)
                                CMD_NEXT: if (dwell_ok) state_nxt = STATE_W'(fwd_idx);
                                          else          rej_nxt   = 1'b1;
                                CMD_PREV: if (dwell_ok) state_nxt = STATE_W'(bwd_idx);
                                          else          rej_nxt   = 1'b1;
                                CMD_JUMP: if (dwell_ok && tgt_ok) state_nxt = target;
                                          else                    rej_nxt   = 1'b1;
                                CMD_HOME: state_nxt  = MODE_HOME;
                                CMD_LOCK: locked_nxt = 1'b1;
                                default:  rej_nxt    = 1'b1;
                            endcase
                        end
                    end
                end
            end
            default: begin
                // Out-of-range state: park at home, locked, and flag it until reset.
                state_nxt  = MODE_HOME;
                locked_nxt = 1'b1;
                fault_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= MODE_HOME;
            locked_r <= 1'b0;
            fault_r  <= 1'b0;
            rej_r    <= 1'b0;
            dwell_r  <= 8'd0;
        end else begin
            state_r  <= state_nxt;
            locked_r <= locked_nxt;
            fault_r  <= fault_nxt;
            rej_r    <= rej_nxt;
            if (state_nxt != state_r)  dwell_r <= 8'd0;
            else if (dwell_r != MIN_D8) dwell_r <= dwell_r + 8'd1;
        end
    end

    always_comb begin
        out = OUT_W'(state_r);
    end

    assign state   = state_r;
    assign locked  = locked_r;
    assign cmd_rej = rej_r;
    assign fault   = fault_r;

endmodule

// File: tb/tb_mode_seq_fsm.sv
// Bench for mode_seq_fsm: four configurations driven from a vector table plus
// hand sequences for illegal-state recovery and reset-versus-command.
module tb_mode_seq_fsm;
    import mode_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 0: N=4 wrap, 1: N=4 saturate, 2: N=4 wrap dwell=3, 3: N=3 wrap
    logic       rst [4];
    logic       vld [4];
    logic [2:0] cmd [4];
    logic [1:0] tgt [4];
    logic [1:0] st  [4];
    logic [2:0] o   [4];
    logic       lk  [4];
    logic       rj  [4];
    logic       ft  [4];

    mode_seq_fsm #(.NUM_STATES(4), .OUT_W(3), .WRAP(1), .MIN_DWELL(0)) u_a (
        .clk(clk), .rst(rst[0]), .in_valid(vld[0]), .user_input(cmd[0]), .target(tgt[0]),
        .out(o[0]), .state(st[0]), .locked(lk[0]), .cmd_rej(rj[0]), .fault(ft[0]));
    mode_seq_fsm #(.NUM_STATES(4), .OUT_W(3), .WRAP(0), .MIN_DWELL(0)) u_b (
        .clk(clk), .rst(rst[1]), .in_valid(vld[1]), .user_input(cmd[1]), .target(tgt[1]),
        .out(o[1]), .state(st[1]), .locked(lk[1]), .cmd_rej(rj[1]), .fault(ft[1]));
    mode_seq_fsm #(.NUM_STATES(4), .OUT_W(3), .WRAP(1), .MIN_DWELL(3)) u_c (
        .clk(clk), .rst(rst[2]), .in_valid(vld[2]), .user_input(cmd[2]), .target(tgt[2]),
        .out(o[2]), .state(st[2]), .locked(lk[2]), .cmd_rej(rj[2]), .fault(ft[2]));
    mode_seq_fsm #(.NUM_STATES(3), .OUT_W(3), .WRAP(1), .MIN_DWELL(0)) u_d (
        .clk(clk), .rst(rst[3]), .in_valid(vld[3]), .user_input(cmd[3]), .target(tgt[3]),
        .out(o[3]), .state(st[3]), .locked(lk[3]), .cmd_rej(rj[3]), .fault(ft[3]));

    typedef struct {
        int         d;
        logic       v;
        logic [2:0] c;
        logic [1:0] t;
        logic [1:0] es;
        logic       el;
        logic       ej;
        logic       ef;
    } vec_t;

    vec_t       vecs [$];
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    // Expected record: {state, out, locked, cmd_rej, fault}
    function automatic logic [7:0] pack(input logic [1:0] s, input logic el,
                                        input logic ej, input logic ef);
        return {s, {1'b0, s}, el, ej, ef};
    endfunction

    task automatic add(input int d, input logic v, input logic [2:0] c, input logic [1:0] t,
                       input logic [1:0] es, input logic el, input logic ej, input logic ef);
        vec_t x;
        x.d = d; x.v = v; x.c = c; x.t = t; x.es = es; x.el = el; x.ej = ej; x.ef = ef;
        vecs.push_back(x);
    endtask

    task automatic compare(input int d, input string name);
        logic [7:0] act;
        logic [7:0] expv;
        act = {st[d], o[d], lk[d], rj[d], ft[d]};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s dut=%0d scoreboard empty, got %b", name, d, act);
        end else begin
            expv = exp_q.pop_front();
            if (act !== expv) begin
                errors++;
                $display("FAIL %s dut=%0d got {st,out,lk,rej,flt}=%b required %b", name, d, act, expv);
            end
        end
    endtask

    task automatic step(input int d, input logic v, input logic [2:0] c, input logic [1:0] t,
                        input logic [7:0] expv, input string name);
        vld[d] = v; cmd[d] = c; tgt[d] = t;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
        compare(d, name);
    endtask

    task automatic check_now(input int d, input logic [7:0] expv, input string name);
        exp_q.push_back(expv);
        compare(d, name);
    endtask

    initial begin
        // Dwell config first so its counter starts from reset.
        add(2, 1, CMD_NEXT,   0, 0, 0, 1, 0);
        add(2, 1, CMD_NEXT,   0, 0, 0, 1, 0);
        add(2, 1, CMD_NEXT,   0, 0, 0, 1, 0);
        add(2, 1, CMD_NEXT,   0, 1, 0, 0, 0);
        add(2, 1, CMD_HOLD,   0, 1, 0, 0, 0);
        add(2, 1, CMD_NEXT,   0, 1, 0, 1, 0);
        add(2, 1, CMD_NEXT,   0, 1, 0, 1, 0);
        add(2, 1, CMD_NEXT,   0, 2, 0, 0, 0);
        add(2, 1, CMD_HOME,   0, 0, 0, 0, 0);
        add(2, 1, CMD_LOCK,   0, 0, 1, 0, 0);
        add(2, 1, CMD_UNLOCK, 0, 0, 0, 0, 0);
        add(2, 1, CMD_JUMP,   0, 0, 0, 1, 0);
        add(2, 1, CMD_JUMP,   0, 0, 0, 0, 0);
        add(2, 1, CMD_JUMP,   3, 3, 0, 0, 0);
        // Wrapping N=4
        add(0, 1, CMD_NEXT,   0, 1, 0, 0, 0);
        add(0, 1, CMD_NEXT,   0, 2, 0, 0, 0);
        add(0, 1, CMD_NEXT,   0, 3, 0, 0, 0);
        add(0, 1, CMD_NEXT,   0, 0, 0, 0, 0);
        add(0, 1, CMD_NEXT,   0, 1, 0, 0, 0);
        add(0, 1, CMD_HOLD,   0, 1, 0, 0, 0);
        add(0, 0, CMD_NEXT,   0, 1, 0, 0, 0);
        add(0, 1, CMD_PREV,   0, 0, 0, 0, 0);
        add(0, 1, CMD_PREV,   0, 3, 0, 0, 0);
        add(0, 1, CMD_HOME,   0, 0, 0, 0, 0);
        add(0, 1, CMD_JUMP,   2, 2, 0, 0, 0);
        add(0, 1, CMD_JUMP,   2, 2, 0, 0, 0);
        add(0, 1, CMD_LOCK,   0, 2, 1, 0, 0);
        add(0, 1, CMD_NEXT,   0, 2, 1, 1, 0);
        add(0, 1, CMD_HOME,   0, 2, 1, 1, 0);
        add(0, 1, CMD_HOLD,   0, 2, 1, 0, 0);
        add(0, 1, CMD_LOCK,   0, 2, 1, 1, 0);
        add(0, 1, CMD_UNLOCK, 0, 2, 0, 0, 0);
        add(0, 1, CMD_UNLOCK, 0, 2, 0, 0, 0);
        add(0, 1, CMD_NEXT,   0, 3, 0, 0, 0);
        add(0, 1, CMD_RSVD,   0, 3, 0, 1, 0);
        add(0, 0, CMD_HOLD,   0, 3, 0, 0, 0);
        // Saturating N=4
        add(1, 1, CMD_PREV,   0, 0, 0, 0, 0);
        add(1, 1, CMD_NEXT,   0, 1, 0, 0, 0);
        add(1, 1, CMD_NEXT,   0, 2, 0, 0, 0);
        add(1, 1, CMD_NEXT,   0, 3, 0, 0, 0);
        add(1, 1, CMD_NEXT,   0, 3, 0, 0, 0);
        add(1, 1, CMD_PREV,   0, 2, 0, 0, 0);
        // N=3
        add(3, 1, CMD_JUMP,   3, 0, 0, 1, 0);
        add(3, 1, CMD_JUMP,   2, 2, 0, 0, 0);
        add(3, 1, CMD_NEXT,   0, 0, 0, 0, 0);
        add(3, 1, CMD_PREV,   0, 2, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1; vld[i] = 1'b0; cmd[i] = 3'd0; tgt[i] = 2'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        for (int i = 0; i < 4; i++) check_now(i, pack(0, 0, 0, 0), "reset");

        foreach (vecs[i])
            step(vecs[i].d, vecs[i].v, vecs[i].c, vecs[i].t,
                 pack(vecs[i].es, vecs[i].el, vecs[i].ej, vecs[i].ef), "vec");

        // Upset the N=3 state register into the unused encoding.
        force u_d.state_r = 2'd3;
        #1;
        release u_d.state_r;
        check_now(3, pack(3, 0, 0, 0), "illegal_visible");
        step(3, 1, CMD_NEXT,   0, pack(0, 1, 0, 1), "illegal_recover");
        step(3, 1, CMD_NEXT,   0, pack(0, 1, 1, 1), "recover_locked");
        step(3, 1, CMD_UNLOCK, 0, pack(0, 0, 0, 1), "fault_sticky");
        rst[3] = 1'b1;
        step(3, 1, CMD_NEXT,   0, pack(0, 0, 0, 0), "fault_reset");
        rst[3] = 1'b0;

        // Reset on the same edge as a command yields reset values.
        rst[0] = 1'b1;
        step(0, 1, CMD_NEXT, 0, pack(0, 0, 0, 0), "rst_vs_cmd");
        rst[0] = 1'b0;
        step(0, 1, CMD_NEXT, 0, pack(1, 0, 0, 0), "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
